cbus_arbiter: RTL and testbench

- Shares the single core-to-memory CBus port (the one feeding CBusToAXI/CBusToSRAM) between NUM_REQ upstream requesters (index 0 = instruction fetch, index 1 = data memory).
- Round-robin arbiter with transaction locking: once granted, a requester owns the bus until its final response beat (ready && last). No request is ever split or interleaved.

---
 rtl/cbus_arbiter_pkg.sv | 25 ++
 rtl/cbus_arbiter_rr_pick.sv | 32 +++
 rtl/cbus_arbiter.sv | 98 +++++++++
 tb/tb_cbus_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus request/response types and arbiter state encoding for the core-to-memory port.
package cbus_arbiter_pkg;

    localparam int unsigned MAX_CBUS_REQ = 8;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i scanning ptr_i, ptr_i+1, ... mod N.
module cbus_arbiter_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    // Distance from the pointer decides priority; the smallest distance wins.
    always_comb begin
        int unsigned p;
        int unsigned d;
        int unsigned best_d;
        any_o  = 1'b0;
        idx_o  = '0;
        p      = 32'(ptr_i);
        d      = 0;
        best_d = N;
        for (int unsigned j = 0; j < N; j++) begin
            d = (j >= p) ? (j - p) : (j + N - p);
            if (valid_i[j] && (d < best_d)) begin
                best_d = d;
                any_o  = 1'b1;
                idx_o  = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin CBus arbiter with whole-transaction locking; the owner keeps the bus until ready && last.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_REQ],
    output cbus_resp_t iresps [NUM_REQ],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_CBUS_REQ) begin : g_num_req_check
        $error("cbus_arbiter: NUM_REQ must be in 2..8");
    end

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [NUM_REQ-1:0] req_valid;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               sel_valid;

    always_comb begin
        req_valid = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = ireqs[i].valid;
            if (sel_q == IDX_W'(i)) begin
                sel_valid = ireqs[i].valid;
            end
        end
    end

    cbus_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        oreq    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            iresps[i] = '0;
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (sel_q == IDX_W'(i)) begin
                        oreq      = ireqs[i];
                        iresps[i] = oresp;
                    end
                end
                if (oresp.ready && oresp.last) begin
                    // Explicit wrap so non-power-of-2 NUM_REQ never reaches an unused index.
                    ptr_d   = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assert property (@(posedge clk) disable iff (reset) (state_q == ARB_BUSY) |-> sel_valid)
        else $error("cbus_arbiter: granted requester dropped valid mid-transaction");

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: vector table, directed corner sequences, random traffic vs. a reference model.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N = 2;
    localparam logic [63:0] RDATA = 64'h0123_4567_89ab_cdef;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  ireqs  [N];
    cbus_resp_t iresps [N];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    logic       reset3;
    cbus_req_t  ireqs3  [3];
    cbus_resp_t iresps3 [3];
    cbus_req_t  oreq3;
    cbus_resp_t oresp3;

    always #5 clk = ~clk;

    cbus_arbiter #(.NUM_REQ(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    cbus_arbiter #(.NUM_REQ(3)) dut3 (
        .clk    (clk),
        .reset  (reset3),
        .ireqs  (ireqs3),
        .iresps (iresps3),
        .oreq   (oreq3),
        .oresp  (oresp3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_req(input string name, input cbus_req_t act, input cbus_req_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string name, input cbus_resp_t act, input cbus_resp_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: who owns the bus (-1 = nobody) and whose turn is next.
    int m_owner = -1;
    int m_ptr   = 0;
    bit m_live  = 1'b0;
    bit m_done [N];

    task automatic model_check();
        cbus_req_t  er;
        cbus_resp_t ers;
        er = '0;
        if (m_owner >= 0) er = ireqs[m_owner];
        check_req("model_oreq", oreq, er);
        for (int i = 0; i < N; i++) begin
            ers = (m_owner == i) ? oresp : '0;
            check_resp($sformatf("model_iresp%0d", i), iresps[i], ers);
        end
    endtask

    task automatic model_update();
        bit found;
        for (int i = 0; i < N; i++) m_done[i] = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_live  = 1'b1;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && ireqs[(m_ptr + k) % N].valid) begin
                    m_owner = (m_ptr + k) % N;
                    found   = 1'b1;
                end
            end
        end else if (oresp.ready && oresp.last) begin
            m_done[m_owner] = 1'b1;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
    endtask

    task automatic settle();
        #1;
        if (m_live) model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic cbus_req_t mk_req(input logic [63:0] addr, input logic wr,
                                         input logic [7:0] len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = 3'd3;
        r.addr     = addr;
        r.strobe   = wr ? 8'hff : 8'h00;
        r.data     = wr ? {addr[31:0], 32'ha5a5_0000} : 64'h0;
        r.len      = len;
        r.burst    = (len != 8'd0) ? 2'b01 : 2'b00;
        return r;
    endfunction

    function automatic cbus_req_t rnd_req();
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = 1'($urandom_range(1));
        r.size     = 3'($urandom_range(3));
        r.addr     = {$urandom, $urandom};
        r.strobe   = 8'($urandom);
        r.data     = {$urandom, $urandom};
        r.len      = 8'($urandom_range(7));
        r.burst    = 2'($urandom_range(2));
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst,
                                           input logic [63:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    typedef struct {
        logic v0;
        logic v1;
        logic rdy;
        logic lst;
        int   src;  // expected owner on the bus, -1 for none
    } vec_t;

    initial begin
        vec_t       tbl [15];
        cbus_req_t  r0, r1, er;
        cbus_resp_t ers;
        int         cnt0, cnt1;
        int         grants [$];

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, -1};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0,  0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1,  0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, -1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, -1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0,  0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1,  0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, -1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1,  1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, -1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, -1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1,  1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, -1};

        reset  = 1'b1;
        reset3 = 1'b1;
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        for (int i = 0; i < 3; i++) ireqs3[i] = '0;
        oresp  = '0;
        oresp3 = '0;
        ireqs[0] = mk_req(64'h1000, 1'b0, 8'd0);
        @(negedge clk);

        // Reset held 3 cycles with a pending request: bus stays quiet.
        for (int c = 0; c < 3; c++) begin
            advance();
            settle();
            check_val("reset_ovalid", 64'(oreq.valid), 64'd0);
            check_resp("reset_iresp0", iresps[0], '0);
            check_resp("reset_iresp1", iresps[1], '0);
        end
        reset = 1'b0;
        settle();
        check_val("post_reset_idle", 64'(oreq.valid), 64'd0);
        advance();
        settle();
        check_req("post_reset_grant", oreq, ireqs[0]);
        oresp = mk_resp(1'b1, 1'b1, RDATA);
        settle();
        advance();
        ireqs[0].valid = 1'b0;
        oresp = '0;

        // Vector table from a fresh reset.
        reset = 1'b1;
        advance();
        reset = 1'b0;
        r0 = mk_req(64'h1000, 1'b0, 8'd1);
        r1 = mk_req(64'h8000_0008, 1'b1, 8'd0);
        for (int k = 0; k < 15; k++) begin
            ireqs[0] = r0;
            ireqs[0].valid = tbl[k].v0;
            ireqs[1] = r1;
            ireqs[1].valid = tbl[k].v1;
            oresp = mk_resp(tbl[k].rdy, tbl[k].lst, RDATA);
            settle();
            er = (tbl[k].src == 0) ? ireqs[0] : (tbl[k].src == 1) ? ireqs[1] : '0;
            check_req($sformatf("vec%0d_oreq", k), oreq, er);
            for (int i = 0; i < N; i++) begin
                ers = (tbl[k].src == i) ? oresp : '0;
                check_resp($sformatf("vec%0d_iresp%0d", k, i), iresps[i], ers);
            end
            advance();
        end

        // Single read on requester 1, response three cycles after the grant.
        ireqs[0] = '0;
        ireqs[1] = mk_req(64'h8000_0008, 1'b0, 8'd0);
        oresp = '0;
        settle();
        advance();
        cnt0 = 0;
        cnt1 = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 3) oresp = mk_resp(1'b1, 1'b1, 64'hdead_beef_0000_0001);
            else oresp = '0;
            if (c == 4) ireqs[1].valid = 1'b0;
            settle();
            if (c < 3) check_req("read_wait_oreq", oreq, ireqs[1]);
            if (c == 3)
                check_resp("read_resp", iresps[1], mk_resp(1'b1, 1'b1, 64'hdead_beef_0000_0001));
            cnt1 += int'(iresps[1].ready);
            cnt0 += int'(iresps[0] != '0);
            advance();
        end
        check_val("read_resp_once", 64'(cnt1), 64'd1);
        check_val("read_iresp0_quiet", 64'(cnt0), 64'd0);

        // Pointer returned to 0: requester 0 wins when both ask.
        ireqs[0] = mk_req(64'h2000, 1'b0, 8'd0);
        ireqs[1] = mk_req(64'h8000_0008, 1'b0, 8'd0);
        settle();
        advance();
        settle();
        check_val("ptr_after_read", oreq.addr, 64'h2000);
        oresp = mk_resp(1'b1, 1'b1, RDATA);
        settle();
        advance();
        ireqs[0].valid = 1'b0;
        oresp = '0;
        settle();
        advance();
        oresp = mk_resp(1'b1, 1'b1, RDATA);
        settle();
        check_val("grant_after_0", oreq.addr, 64'h8000_0008);
        advance();
        ireqs[1].valid = 1'b0;
        oresp = '0;
        settle();
        advance();

        // Burst lock: 4-beat burst from requester 0 while requester 1 waits.
        ireqs[0] = mk_req(64'h3000, 1'b1, 8'd3);
        ireqs[1] = mk_req(64'h4000, 1'b0, 8'd0);
        settle();
        advance();
        for (int b = 0; b < 4; b++) begin
            oresp = mk_resp(1'b1, b == 3, 64'(b));
            settle();
            check_req($sformatf("burst_beat%0d", b), oreq, ireqs[0]);
            check_resp($sformatf("burst_iresp1_%0d", b), iresps[1], '0);
            advance();
        end
        ireqs[0].valid = 1'b0;
        oresp = '0;
        settle();
        check_val("burst_gap", 64'(oreq.valid), 64'd0);
        advance();
        settle();
        check_req("burst_then_req1", oreq, ireqs[1]);
        oresp = mk_resp(1'b1, 1'b1, RDATA);
        settle();
        advance();
        ireqs[1].valid = 1'b0;
        oresp = '0;
        settle();
        advance();

        // Reset in the middle of a burst, with the pointer first moved to 1.
        ireqs[0] = mk_req(64'h5000, 1'b0, 8'd0);
        settle();
        advance();
        oresp = mk_resp(1'b1, 1'b1, RDATA);
        settle();
        advance();
        oresp = '0;
        ireqs[0] = mk_req(64'h5800, 1'b0, 8'd3);
        settle();
        advance();
        for (int b = 0; b < 2; b++) begin
            oresp = mk_resp(1'b1, 1'b0, 64'(b));
            settle();
            advance();
        end
        reset = 1'b1;
        ireqs[0].valid = 1'b0;
        oresp = '0;
        settle();
        advance();
        reset = 1'b0;
        settle();
        check_val("reset_mid_burst", 64'(oreq.valid), 64'd0);
        ireqs[0] = mk_req(64'h5000, 1'b0, 8'd0);
        ireqs[1] = mk_req(64'h6000, 1'b0, 8'd0);
        settle();
        advance();
        settle();
        check_val("ptr_after_reset", oreq.addr, 64'h5000);
        oresp = mk_resp(1'b1, 1'b1, 64'hfeed_0000_0000_0005);
        settle();
        check_resp("fresh_read_resp", iresps[0], mk_resp(1'b1, 1'b1, 64'hfeed_0000_0000_0005));
        advance();
        ireqs[0] = '0;
        ireqs[1] = '0;
        oresp = '0;
        settle();
        advance();

        // Random traffic against the reference model.
        reset = 1'b1;
        advance();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_done[i]) ireqs[i].valid = 1'b0;
                else if (!ireqs[i].valid && ($urandom_range(2) == 0)) ireqs[i] = rnd_req();
            end
            oresp = mk_resp(1'($urandom_range(1)), $urandom_range(2) == 0, {$urandom, $urandom});
            reset = ($urandom_range(199) == 0);
            settle();
            advance();
        end
        reset = 1'b1;
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        oresp = '0;
        advance();
        reset = 1'b0;
        settle();

        // Three requesters, index 1 never asks: grants alternate 0,2.
        ireqs3[0] = mk_req(64'h1000, 1'b0, 8'd0);
        ireqs3[2] = mk_req(64'h3000, 1'b0, 8'd0);
        oresp3 = mk_resp(1'b1, 1'b1, RDATA);
        advance();
        reset3 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (oreq3.valid) begin
                grants.push_back((oreq3.addr == 64'h1000) ? 0 : (oreq3.addr == 64'h3000) ? 2 : 1);
            end
            check_resp($sformatf("n3_iresp1_c%0d", c), iresps3[1], '0);
            advance();
        end
        check_val("n3_grant_count", 64'(grants.size()), 64'd4);
        for (int g = 0; g < 4; g++) begin
            if (g < grants.size())
                check_val($sformatf("n3_grant%0d", g), 64'(grants[g]), (g % 2 == 0) ? 64'd0 : 64'd2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
